ternary_fwd_scoreboard: RTL and testbench

Parametrised N-issue forwarding and load-use hazard unit for the ternary pipeline. Each cycle it accepts the bundle currently in EX (up to `ISSUE_W` slots) and shifts its destination info through an internal `DEPTH`-stage tracking pipeline mirroring MEM/WB/later stages. It produces per-operand bypass selects, including same-cycle intra-bundle forwarding from any older slot. It also raises a load-use stall when the youngest matching producer's data is not yet available. It sits beside the EX stage and replaces hand-written per-slot forwarding comparators.

---
 rtl/ternary_fwd_scoreboard_pkg.sv | 40 ++++
 rtl/ternary_fwd_match.sv | 45 ++++
 rtl/ternary_fwd_scoreboard.sv | 139 +++++++++++++
 tb/tb_ternary_fwd_scoreboard.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ternary_fwd_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ternary_fwd_scoreboard_pkg
//  Description : Shared trit/address types, tracking-entry struct and
//                producer/address-compare helpers for the forwarding unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package ternary_fwd_scoreboard_pkg;

    typedef logic [1:0] trit_t;

    localparam trit_t T_ZERO = 2'b00;
    localparam trit_t T_POS  = 2'b01;
    localparam trit_t T_NEG  = 2'b10;

    typedef trit_t [2:0] taddr_t;

    localparam int FWD_SEL_RF = 0;

    typedef struct packed {
        logic   valid;
        taddr_t rd;
        logic   we;
        logic   late;
    } fwd_entry_t;

    function automatic logic is_r0(input taddr_t a);
        return (a == {T_ZERO, T_ZERO, T_ZERO});
    endfunction

    function automatic logic addr_eq(input taddr_t a, input taddr_t b);
        return (a == b);
    endfunction

    function automatic logic is_producer(input fwd_entry_t e);
        return e.valid && e.we && !is_r0(e.rd);
    endfunction

endpackage : ternary_fwd_scoreboard_pkg
`default_nettype wire

// File: rtl/ternary_fwd_match.sv
`default_nettype none
// ============================================================================
//  Module      : ternary_fwd_match
//  Description : Combinational priority search for one source operand over
//                the EX bundle and all tracked stages; returns select + ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module ternary_fwd_match
    import ternary_fwd_scoreboard_pkg::*;
#(
    parameter int ISSUE_W     = 2,
    parameter int DEPTH       = 2,
    parameter int LATE_STAGES = 1,
    parameter int CONS_SLOT   = 0,
    parameter int SEL_W       = 3
) (
    input  logic                                   i_cons_valid,
    input  taddr_t                                 i_rs,
    input  fwd_entry_t [(DEPTH+1)*ISSUE_W-1:0]     i_cand,
    output logic [SEL_W-1:0]                       o_sel,
    output logic                                   o_ready
);

    // Scan from lowest to highest priority so the last hit is the youngest
    // producer: oldest stage first, and lower slots before higher ones.
    always_comb begin
        o_sel   = SEL_W'(FWD_SEL_RF);
        o_ready = 1'b1;
        if (i_cons_valid) begin
            for (int st = DEPTH; st >= 0; st--) begin
                for (int sl = 0; sl < ISSUE_W; sl++) begin
                    if ((st != 0 || sl < CONS_SLOT) &&
                        is_producer(i_cand[st*ISSUE_W + sl]) &&
                        addr_eq(i_cand[st*ISSUE_W + sl].rd, i_rs)) begin
                        o_sel   = SEL_W'(1 + st*ISSUE_W + sl);
                        // A load result is usable only once it has left stage LATE_STAGES.
                        o_ready = !(i_cand[st*ISSUE_W + sl].late && (st <= LATE_STAGES));
                    end
                end
            end
        end
    end

endmodule : ternary_fwd_match
`default_nettype wire

// File: rtl/ternary_fwd_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : ternary_fwd_scoreboard
//  Description : N-issue forwarding select and load-use stall unit with a
//                DEPTH-stage destination tracking pipeline. Optional
//                performance counters enabled by TERNARY_FWD_PERF_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module ternary_fwd_scoreboard
    import ternary_fwd_scoreboard_pkg::*;
#(
    parameter int  ISSUE_W     = 2,
    parameter int  DEPTH       = 2,
    parameter int  LATE_STAGES = 1,
    localparam int SEL_W       = $clog2((DEPTH+1)*ISSUE_W + 1)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              hold,
    input  logic                              flush,
    input  logic   [ISSUE_W-1:0]              ex_valid,
    input  taddr_t [ISSUE_W-1:0]              ex_rd,
    input  logic   [ISSUE_W-1:0]              ex_we,
    input  logic   [ISSUE_W-1:0]              ex_late,
    input  taddr_t [ISSUE_W-1:0]              ex_rs1,
    input  taddr_t [ISSUE_W-1:0]              ex_rs2,
    output logic   [ISSUE_W-1:0][SEL_W-1:0]   fwd_sel_rs1,
    output logic   [ISSUE_W-1:0][SEL_W-1:0]   fwd_sel_rs2,
    output logic                              stall,
    output logic   [31:0]                     perf_stall_cnt,
    output logic   [31:0]                     perf_fwd_cnt
);

    localparam int c_ncand = (DEPTH+1)*ISSUE_W;

    fwd_entry_t [DEPTH:1][ISSUE_W-1:0] r_pipe;
    fwd_entry_t [ISSUE_W-1:0]          w_ex;
    fwd_entry_t [ISSUE_W-1:0]          w_rec;
    fwd_entry_t [c_ncand-1:0]          w_cand;
    logic       [2*ISSUE_W-1:0]        w_ready;

    generate
        for (genvar s = 0; s < ISSUE_W; s++) begin : g_slot
            always_comb begin
                w_ex[s].valid = ex_valid[s];
                w_ex[s].rd    = ex_rd[s];
                w_ex[s].we    = ex_we[s];
                w_ex[s].late  = ex_late[s];
                w_rec[s]       = w_ex[s];
                w_rec[s].valid = ex_valid[s] & ~flush & ~stall;
            end

            assign w_cand[s] = w_ex[s];

            for (genvar st = 1; st <= DEPTH; st++) begin : g_stage
                assign w_cand[st*ISSUE_W + s] = r_pipe[st][s];
            end

            ternary_fwd_match #(
                .ISSUE_W     (ISSUE_W),
                .DEPTH       (DEPTH),
                .LATE_STAGES (LATE_STAGES),
                .CONS_SLOT   (s),
                .SEL_W       (SEL_W)
            ) u_match_rs1 (
                .i_cons_valid (ex_valid[s]),
                .i_rs         (ex_rs1[s]),
                .i_cand       (w_cand),
                .o_sel        (fwd_sel_rs1[s]),
                .o_ready      (w_ready[2*s])
            );

            ternary_fwd_match #(
                .ISSUE_W     (ISSUE_W),
                .DEPTH       (DEPTH),
                .LATE_STAGES (LATE_STAGES),
                .CONS_SLOT   (s),
                .SEL_W       (SEL_W)
            ) u_match_rs2 (
                .i_cons_valid (ex_valid[s]),
                .i_rs         (ex_rs2[s]),
                .i_cand       (w_cand),
                .o_sel        (fwd_sel_rs2[s]),
                .o_ready      (w_ready[2*s+1])
            );
        end
    endgenerate

    assign stall = ~&w_ready;

    // A stalled bundle stays in EX, so stage 1 takes a bubble (w_rec invalid).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe <= '0;
        end else if (!hold) begin
            for (int k = DEPTH; k > 1; k--) begin
                r_pipe[k] <= r_pipe[k-1];
            end
            r_pipe[1] <= w_rec;
        end
    end

`ifdef TERNARY_FWD_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_fwd;
    logic        w_fwd_any;

    always_comb begin
        w_fwd_any = 1'b0;
        for (int s = 0; s < ISSUE_W; s++) begin
            if (ex_valid[s] && ((fwd_sel_rs1[s] != '0) || (fwd_sel_rs2[s] != '0))) begin
                w_fwd_any = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_stall <= '0;
            r_perf_fwd   <= '0;
        end else begin
            if (stall && !hold && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (w_fwd_any && (r_perf_fwd != '1)) begin
                r_perf_fwd <= r_perf_fwd + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = r_perf_stall;
    assign perf_fwd_cnt   = r_perf_fwd;
`else
    assign perf_stall_cnt = 32'd0;
    assign perf_fwd_cnt   = 32'd0;
`endif

endmodule : ternary_fwd_scoreboard
`default_nettype wire

// File: tb/tb_ternary_fwd_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ternary_fwd_scoreboard
//  Description : Directed self-checking bench for ternary_fwd_scoreboard
//                (ISSUE_W=2, DEPTH=2, LATE_STAGES=1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ternary_fwd_scoreboard;
    import ternary_fwd_scoreboard_pkg::*;

    localparam int ISSUE_W = 2;
    localparam int DEPTH   = 2;
    localparam int LATE    = 1;
    localparam int SEL_W   = $clog2((DEPTH+1)*ISSUE_W + 1);

    logic                            clk;
    logic                            rst_n;
    logic                            hold;
    logic                            flush;
    logic   [ISSUE_W-1:0]            ex_valid;
    taddr_t [ISSUE_W-1:0]            ex_rd;
    logic   [ISSUE_W-1:0]            ex_we;
    logic   [ISSUE_W-1:0]            ex_late;
    taddr_t [ISSUE_W-1:0]            ex_rs1;
    taddr_t [ISSUE_W-1:0]            ex_rs2;
    logic   [ISSUE_W-1:0][SEL_W-1:0] fwd_sel_rs1;
    logic   [ISSUE_W-1:0][SEL_W-1:0] fwd_sel_rs2;
    logic                            stall;
    logic   [31:0]                   perf_stall_cnt;
    logic   [31:0]                   perf_fwd_cnt;

    int n_vec  = 0;
    int n_miss = 0;

    // Balanced-ternary register addresses
    localparam taddr_t R0 = {T_ZERO, T_ZERO, T_ZERO};
    localparam taddr_t R1 = {T_ZERO, T_ZERO, T_POS};
    localparam taddr_t R3 = {T_ZERO, T_POS,  T_ZERO};
    localparam taddr_t R5 = {T_POS,  T_NEG,  T_NEG};
    localparam taddr_t R6 = {T_POS,  T_NEG,  T_ZERO};
    localparam taddr_t R7 = {T_POS,  T_NEG,  T_POS};

`ifdef TERNARY_FWD_PERF_EN
    localparam logic [31:0] EXP_PRE_STALL = 32'd1;
    localparam logic [31:0] EXP_STALL5    = 32'd5;
    localparam logic [31:0] EXP_FWD5      = 32'd5;
`else
    localparam logic [31:0] EXP_PRE_STALL = 32'd0;
    localparam logic [31:0] EXP_STALL5    = 32'd0;
    localparam logic [31:0] EXP_FWD5      = 32'd0;
`endif

    ternary_fwd_scoreboard #(
        .ISSUE_W     (ISSUE_W),
        .DEPTH       (DEPTH),
        .LATE_STAGES (LATE)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .hold           (hold),
        .flush          (flush),
        .ex_valid       (ex_valid),
        .ex_rd          (ex_rd),
        .ex_we          (ex_we),
        .ex_late        (ex_late),
        .ex_rs1         (ex_rs1),
        .ex_rs2         (ex_rs2),
        .fwd_sel_rs1    (fwd_sel_rs1),
        .fwd_sel_rs2    (fwd_sel_rs2),
        .stall          (stall),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_fwd_cnt   (perf_fwd_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_slot(input int s, input logic v, input taddr_t rd, input logic we,
                            input logic late, input taddr_t rs1, input taddr_t rs2);
        ex_valid[s] = v;
        ex_rd[s]    = rd;
        ex_we[s]    = we;
        ex_late[s]  = late;
        ex_rs1[s]   = rs1;
        ex_rs2[s]   = rs2;
    endtask

    task automatic clear_ex();
        for (int s = 0; s < ISSUE_W; s++) set_slot(s, 1'b0, R0, 1'b0, 1'b0, R0, R0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        hold  = 1'b0;
        flush = 1'b0;
        clear_ex();
        #2;
        chk("reset_sel", 32'(fwd_sel_rs1[0]), 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_perf", perf_stall_cnt, 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Intra-bundle forward, then age through stage 1 and stage 2
        set_slot(0, 1'b1, R5, 1'b1, 1'b0, R1, R1);
        set_slot(1, 1'b1, R1, 1'b0, 1'b0, R5, R0);
        #1;
        chk("intra_sel", 32'(fwd_sel_rs1[1]), 32'd1);
        chk("intra_stall", 32'(stall), 32'd0);
        chk("intra_none", 32'(fwd_sel_rs1[0]), 32'd0);
        tick();
        set_slot(0, 1'b1, R0, 1'b0, 1'b0, R5, R0);
        set_slot(1, 1'b1, R0, 1'b0, 1'b0, R1, R5);
        #1;
        chk("stage1_rs1", 32'(fwd_sel_rs1[0]), 32'd3);
        chk("stage1_rs2", 32'(fwd_sel_rs2[1]), 32'd3);
        tick();
        chk("stage2_sel", 32'(fwd_sel_rs1[0]), 32'd5);
        tick();
        chk("retired_sel", 32'(fwd_sel_rs1[0]), 32'd0);

        // Load-use: one stall cycle, then stage 2 slot 0
        clear_ex();
        set_slot(0, 1'b1, R3, 1'b1, 1'b1, R0, R0);
        #1;
        chk("load_nostall", 32'(stall), 32'd0);
        tick();
        clear_ex();
        set_slot(0, 1'b1, R0, 1'b0, 1'b0, R3, R0);
        #1;
        chk("lu_stall", 32'(stall), 32'd1);
        chk("lu_sel_s1", 32'(fwd_sel_rs1[0]), 32'd3);
        tick();
        chk("lu_release", 32'(stall), 32'd0);
        chk("lu_sel_s2", 32'(fwd_sel_rs1[0]), 32'd5);
        tick();

        // R7 priority: younger stage wins, then higher slot, EX beats all
        clear_ex();
        set_slot(1, 1'b1, R7, 1'b1, 1'b0, R0, R0);
        tick();
        clear_ex();
        set_slot(0, 1'b1, R7, 1'b1, 1'b0, R0, R0);
        tick();
        clear_ex();
        set_slot(0, 1'b1, R0, 1'b0, 1'b0, R0, R7);
        #1;
        chk("r7_stage_prio", 32'(fwd_sel_rs2[0]), 32'd3);
        tick();
        set_slot(0, 1'b1, R7, 1'b1, 1'b0, R0, R0);
        set_slot(1, 1'b1, R7, 1'b1, 1'b0, R7, R0);
        #1;
        chk("r7_ex_prio", 32'(fwd_sel_rs1[1]), 32'd1);
        tick();
        clear_ex();
        set_slot(0, 1'b1, R0, 1'b0, 1'b0, R7, R0);
        #1;
        chk("r7_slot_prio", 32'(fwd_sel_rs1[0]), 32'd4);
        tick();

        // R0 never forwards
        set_slot(0, 1'b1, R0, 1'b1, 1'b0, R0, R0);
        set_slot(1, 1'b1, R0, 1'b1, 1'b0, R0, R0);
        tick();
        tick();
        #1;
        chk("r0_rs1", 32'(fwd_sel_rs1[1]), 32'd0);
        chk("r0_rs2", 32'(fwd_sel_rs2[1]), 32'd0);

        // Hold freezes stage 1 producer; invalid consumer gets 0
        clear_ex();
        set_slot(0, 1'b1, R5, 1'b1, 1'b0, R0, R0);
        tick();
        clear_ex();
        set_slot(0, 1'b1, R0, 1'b0, 1'b0, R5, R0);
        set_slot(1, 1'b0, R0, 1'b0, 1'b0, R5, R0);
        hold = 1'b1;
        #1;
        chk("hold_sel0", 32'(fwd_sel_rs1[0]), 32'd3);
        chk("invalid_cons", 32'(fwd_sel_rs1[1]), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_sel", 32'(fwd_sel_rs1[0]), 32'd3);
        end
        hold = 1'b0;
        tick();
        chk("unhold_sel", 32'(fwd_sel_rs1[0]), 32'd5);

        // Flushed bundle is never forwarded
        clear_ex();
        set_slot(0, 1'b1, R6, 1'b1, 1'b0, R0, R0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        clear_ex();
        set_slot(0, 1'b1, R0, 1'b0, 1'b0, R6, R0);
        #1;
        chk("flush_s1", 32'(fwd_sel_rs1[0]), 32'd0);
        tick();
        chk("flush_s2", 32'(fwd_sel_rs1[0]), 32'd0);

        // Mid-stream reset and stall counter
        clear_ex();
        set_slot(0, 1'b1, R1, 1'b1, 1'b0, R0, R0);
        tick();
        clear_ex();
        set_slot(0, 1'b1, R0, 1'b0, 1'b0, R1, R0);
        #1;
        chk("prereset_sel", 32'(fwd_sel_rs1[0]), 32'd3);
        chk("prereset_perf", perf_stall_cnt, EXP_PRE_STALL);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_sel", 32'(fwd_sel_rs1[0]), 32'd0);
        chk("rst_perf_stall", perf_stall_cnt, 32'd0);
        chk("rst_perf_fwd", perf_fwd_cnt, 32'd0);
        clear_ex();
        set_slot(0, 1'b1, R3, 1'b1, 1'b1, R0, R0);
        set_slot(1, 1'b1, R0, 1'b0, 1'b0, R3, R0);
        #1;
        chk("rst_ex_stall", 32'(stall), 32'd1);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("perf_stall5", perf_stall_cnt, EXP_STALL5);
        chk("perf_fwd5", perf_fwd_cnt, EXP_FWD5);
        chk("same_bundle_sel", 32'(fwd_sel_rs1[1]), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_ternary_fwd_scoreboard
`default_nettype wire
